// File: rtl/bit_unpacker.sv
// rtl/bit_unpacker.sv - 64-bit bit reservoir fed from a 32-bit word FIFO, serving 1..4 bit requests LSB-first
// Valid bits live in res_q[cnt_q-1:0]; every bit above cnt_q is kept zero so an arriving word can simply be OR-ed in.
module bit_unpacker #(
    parameter int DW   = 32,
    parameter int LENW = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [DW-1:0]   fifo_data,
    output logic            fifo_pop,
    input  logic            reqin,
    input  logic [3:0]      reqlen,
    output logic            reqready,
    output logic            pushout,
    output logic [3:0]      dataout,
    output logic [LENW-1:0] lenout,
    output logic            req_err
);

    localparam int BW = 2 * DW;
    localparam int CW = $clog2(BW + 1);

    logic [BW-1:0]   res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fill_pend_q, fill_pend_d;
    logic            req_pend_q, req_pend_d;
    logic [2:0]      req_len_q, req_len_d;
    logic            pushout_q, pushout_d;
    logic [3:0]      dataout_q, dataout_d;
    logic [LENW-1:0] lenout_q, lenout_d;
    logic            req_err_q, req_err_d;

    logic            accept;
    logic            len_legal;
    logic            serve_now;
    logic            serve_pend;
    logic [2:0]      n;
    logic [CW-1:0]   cnt_left;
    logic [BW-1:0]   shifted;
    logic [3:0]      nib_mask;

    // Popping only at cnt<=DW guarantees the word arriving next cycle always fits.
    assign fifo_pop = reset && !fifo_empty && !fill_pend_q && (cnt_q <= CW'(DW));
    assign reqready = !req_pend_q;
    assign pushout  = pushout_q;
    assign dataout  = dataout_q;
    assign lenout   = lenout_q;
    assign req_err  = req_err_q;

    always_comb begin
        res_d       = res_q;
        cnt_d       = cnt_q;
        fill_pend_d = fifo_pop;
        req_pend_d  = req_pend_q;
        req_len_d   = req_len_q;
        pushout_d   = 1'b0;
        dataout_d   = dataout_q;
        lenout_d    = lenout_q;
        req_err_d   = 1'b0;

        accept     = reqin && reqready;
        len_legal  = (reqlen != 4'd0) && (reqlen <= 4'd4);
        serve_now  = accept && len_legal && (CW'(reqlen) <= cnt_q);
        serve_pend = req_pend_q && (CW'(req_len_q) <= cnt_q);

        n = 3'd0;
        if (serve_pend) begin
            n = req_len_q;
        end else if (serve_now) begin
            n = reqlen[2:0];
        end

        shifted  = res_q >> n;
        cnt_left = cnt_q - CW'(n);
        nib_mask = ~(4'hF << n);

        res_d = shifted;
        cnt_d = cnt_left;
        if (fill_pend_q) begin
            res_d = shifted | ({{DW{1'b0}}, fifo_data} << cnt_left);
            cnt_d = cnt_left + CW'(DW);
        end

        if (serve_now || serve_pend) begin
            pushout_d = 1'b1;
            dataout_d = res_q[3:0] & nib_mask;
            lenout_d  = lenout_q + LENW'(n);
        end

        if (serve_pend) begin
            req_pend_d = 1'b0;
        end else if (accept && len_legal && !serve_now) begin
            req_pend_d = 1'b1;
            req_len_d  = reqlen[2:0];
        end

        req_err_d = accept && !len_legal;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_q       <= '0;
            cnt_q       <= '0;
            fill_pend_q <= 1'b0;
            req_pend_q  <= 1'b0;
            req_len_q   <= 3'd0;
            pushout_q   <= 1'b0;
            dataout_q   <= 4'd0;
            lenout_q    <= '0;
            req_err_q   <= 1'b0;
        end else begin
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            fill_pend_q <= fill_pend_d;
            req_pend_q  <= req_pend_d;
            req_len_q   <= req_len_d;
            pushout_q   <= pushout_d;
            dataout_q   <= dataout_d;
            lenout_q    <= lenout_d;
            req_err_q   <= req_err_d;
        end
    end

endmodule

// File: tb/tb_bit_unpacker.sv
// tb/tb_bit_unpacker.sv - directed self-checking bench for bit_unpacker
// A small behavioral word FIFO with a registered read port feeds the DUT.
module tb_bit_unpacker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_data = 32'd0;
    logic        fifo_pop;
    logic        reqin = 1'b0;
    logic [3:0]  reqlen = 4'd0;
    logic        reqready;
    logic        pushout;
    logic [3:0]  dataout;
    logic [14:0] lenout;
    logic        req_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] fmem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    bit_unpacker #(.DW(32), .LENW(15)) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .reqin      (reqin),
        .reqlen     (reqlen),
        .reqready   (reqready),
        .pushout    (pushout),
        .dataout    (dataout),
        .lenout     (lenout),
        .req_err    (req_err)
    );

    always #5 clock = ~clock;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clock) begin
        if (fifo_pop) begin
            fifo_data <= fmem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            checks++;
            if (fifo_pop && dut.cnt_q > 7'd32) begin
                errors++;
                $display("FAIL pop_headroom cnt=%0d required <=32 when popping", dut.cnt_q);
            end
            checks++;
            if (dut.cnt_q > 7'd64) begin
                errors++;
                $display("FAIL cnt_bound cnt=%0d required <=64", dut.cnt_q);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  len;
        logic        err;
        logic [3:0]  data;
        logic [14:0] lenv;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic fifo_push(input logic [31:0] w);
        fmem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [31:0] wgen(input int i);
        return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h0F0F5A5A;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset  = 1'b0;
        reqin  = 1'b0;
        wr_ptr = rd_ptr;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Continuous 4-bit requests; expected nibbles come from the wgen word sequence.
    task automatic run_stream(input int nreq);
        int acc = 0;
        int got = 0;
        int wi  = 0;
        int cyc = 0;
        logic [31:0] w;
        logic [3:0]  nib;
        while (got < nreq && cyc < nreq * 4 + 200) begin
            @(negedge clock);
            cyc++;
            if (pushout) begin
                w   = wgen(got / 8);
                nib = 4'(w >> (4 * (got % 8)));
                got++;
                chk("stream_data", {28'd0, dataout}, {28'd0, nib});
                chk("stream_len", {17'd0, lenout}, {17'd0, 15'(4 * got)});
            end
            if (wi < nreq / 8 && (wr_ptr - rd_ptr) < 4) begin
                fifo_push(wgen(wi));
                wi++;
            end
            reqin  = (acc < nreq);
            reqlen = 4'd4;
            if (reqin && reqready) acc++;
        end
        reqin = 1'b0;
        chk("stream_count", got, nreq);
    endtask

    initial begin
        int first;

        tbl[0]  = '{4'd4,  1'b0, 4'hD, 15'd4};
        tbl[1]  = '{4'd4,  1'b0, 4'h0, 15'd8};
        tbl[2]  = '{4'd3,  1'b0, 4'h0, 15'd11};
        tbl[3]  = '{4'd0,  1'b1, 4'h0, 15'd11};
        tbl[4]  = '{4'd9,  1'b1, 4'h0, 15'd11};
        tbl[5]  = '{4'd1,  1'b0, 4'h0, 15'd12};
        tbl[6]  = '{4'd4,  1'b0, 4'hF, 15'd16};
        tbl[7]  = '{4'd2,  1'b0, 4'h1, 15'd18};
        tbl[8]  = '{4'd2,  1'b0, 4'h1, 15'd20};
        tbl[9]  = '{4'd4,  1'b0, 4'hA, 15'd24};
        tbl[10] = '{4'd3,  1'b0, 4'h5, 15'd27};
        tbl[11] = '{4'd15, 1'b1, 4'h0, 15'd27};
        tbl[12] = '{4'd4,  1'b0, 4'h4, 15'd31};
        tbl[13] = '{4'd2,  1'b0, 4'h1, 15'd33};
        tbl[14] = '{4'd4,  1'b0, 4'hC, 15'd37};
        tbl[15] = '{4'd3,  1'b0, 4'h3, 15'd40};
        tbl[16] = '{4'd4,  1'b0, 4'h6, 15'd44};

        // Reset values while reset is held with a non-empty FIFO
        fifo_push(32'hA5A5F00D);
        fifo_push(32'h12345678);
        repeat (2) @(negedge clock);
        chk("rst_pop", fifo_pop, 0);
        chk("rst_ready", reqready, 1);
        chk("rst_push", pushout, 0);
        chk("rst_data", dataout, 0);
        chk("rst_len", lenout, 0);
        chk("rst_err", req_err, 0);
        reset = 1'b1;

        // Reservoir fills to 64 bits, then the table drains 44 of them
        repeat (6) @(negedge clock);
        chk("fill_cnt", dut.cnt_q, 64);
        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            reqin  = 1'b1;
            reqlen = tbl[i].len;
            @(negedge clock);
            reqin = 1'b0;
            chk($sformatf("vec%0d_push", i), pushout, !tbl[i].err);
            chk($sformatf("vec%0d_err", i), req_err, tbl[i].err);
            if (!tbl[i].err) chk($sformatf("vec%0d_data", i), dataout, tbl[i].data);
            chk($sformatf("vec%0d_len", i), lenout, tbl[i].lenv);
            chk($sformatf("vec%0d_cnt", i), dut.cnt_q, 32'(64 - int'(tbl[i].lenv)));
        end
        @(negedge clock);
        chk("err_single_pulse", req_err, 0);
        chk("push_single_pulse", pushout, 0);

        // Pending request on an empty reservoir
        do_reset();
        @(negedge clock);
        reqin  = 1'b1;
        reqlen = 4'd2;
        @(negedge clock);
        reqin = 1'b0;
        chk("pend_ready_low", reqready, 0);
        chk("pend_no_push", pushout, 0);
        first = 0;
        repeat (3) begin
            @(negedge clock);
            if (pushout) first = -1;
        end
        chk("pend_idle_no_push", first, 0);
        fifo_push(32'h00000003);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 2) chk("pend_cnt_arrived", dut.cnt_q, 32);
            if (pushout && first == 0) begin
                first = i;
                chk("pend_data", dataout, 3);
                chk("pend_ready_high", reqready, 1);
                chk("pend_len", lenout, 2);
            end
        end
        chk("pend_latency", first, 3);

        // Three words streamed with back-to-back 4-bit requests
        do_reset();
        run_stream(24);
        chk("stream3_len_final", lenout, 96);

        // Reset lands while a popped word is in flight
        @(negedge clock);
        fifo_push(32'h11111111);
        fifo_push(32'h2222222F);
        @(negedge clock);
        chk("flight_pend", dut.fill_pend_q, 1);
        reset = 1'b0;
        #1;
        chk("flight_rst_pop", fifo_pop, 0);
        chk("flight_rst_ready", reqready, 1);
        chk("flight_rst_push", pushout, 0);
        chk("flight_rst_data", dataout, 0);
        chk("flight_rst_len", lenout, 0);
        chk("flight_rst_err", req_err, 0);
        chk("flight_rst_fill", dut.fill_pend_q, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("flight_cnt_zero", dut.cnt_q, 0);
        reqin  = 1'b1;
        reqlen = 4'd4;
        @(negedge clock);
        reqin = 1'b0;
        first = 0;
        for (int i = 0; i < 10 && first == 0; i++) begin
            if (pushout) first = 1;
            else @(negedge clock);
        end
        chk("flight_served", first, 1);
        chk("flight_data", dataout, 4'hF);
        chk("flight_len", lenout, 4);

        // 32768 delivered bits wrap the counter to zero
        do_reset();
        run_stream(8192);
        chk("wrap_len", lenout, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
